// File: rtl/piped_adder_accum.sv
// piped_adder_accum: integrate-and-dump accumulator placed behind an adder tree.
// Sums dump_len valid samples per period and dumps each sum into a one-deep
// output register with a valid/ready handshake; periods run back to back.
// Optional feature macro: ACCUM_SAT_EN -- saturating accumulate steps and an
// out_sat flag per dump. Without it the accumulator wraps and out_sat stays 0.
module piped_adder_accum #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  input  logic [LEN_WIDTH-1:0]        dump_len,
  input  logic                        start,
  input  logic                        stop,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sat,
  output logic                        overrun,
  output logic                        busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 satPeriod_q, satPeriod_d;
  logic [ACC_WIDTH-1:0] outData_q, outData_d;
  logic                 outValid_q, outValid_d;
  logic                 outSat_q, outSat_d;
  logic                 overrun_q, overrun_d;

  logic                 sampleEn;
  logic                 lastSample;
  logic                 loadOut;
  logic                 stepSat;
  logic [ACC_WIDTH-1:0] inExt;
  logic [ACC_WIDTH-1:0] sumNext;
  logic [LEN_WIDTH-1:0] lenLast;

  // A sample counts only while running and when no start/stop is being taken.
  assign inExt      = ACC_WIDTH'(in_data);
  assign lenLast    = len_q - LEN_WIDTH'(1);
  assign sampleEn   = (state_q == RUN) && in_valid && !start && !stop;
  assign lastSample = sampleEn && (cnt_q == lenLast);
  assign loadOut    = lastSample && (!outValid_q || out_ready);

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] sumWide;

  // One extra bit exposes signed overflow; clamp toward the overflowed side.
  always_comb begin
    sumWide = {acc_q[ACC_WIDTH-1], acc_q} + {inExt[ACC_WIDTH-1], inExt};
    stepSat = sumWide[ACC_WIDTH] != sumWide[ACC_WIDTH-1];
    sumNext = sumWide[ACC_WIDTH-1:0];
    if (stepSat) begin
      sumNext = sumWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign stepSat = 1'b0;
  assign sumNext = acc_q + inExt;
`endif

  // Period control: start restarts everything, stop aborts, the last sample
  // of a period clears the accumulator so the next period follows with no gap.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    satPeriod_d = satPeriod_q;
    overrun_d   = overrun_q;
    if (start) begin
      state_d     = RUN;
      acc_d       = '0;
      cnt_d       = '0;
      len_d       = (dump_len == '0) ? LEN_WIDTH'(1) : dump_len;
      satPeriod_d = 1'b0;
      overrun_d   = 1'b0;
    end else if (stop && (state_q == RUN)) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      satPeriod_d = 1'b0;
    end else if (lastSample) begin
      acc_d       = '0;
      cnt_d       = '0;
      satPeriod_d = 1'b0;
      if (!loadOut) begin
        overrun_d = 1'b1;
      end
    end else if (sampleEn) begin
      acc_d       = sumNext;
      cnt_d       = cnt_q + LEN_WIDTH'(1);
      satPeriod_d = satPeriod_q | stepSat;
    end
  end

  // Output slot: load a dump when the slot is free or being drained,
  // otherwise empty it after a handshake.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outSat_d   = outSat_q;
    if (loadOut) begin
      outData_d  = sumNext;
      outValid_d = 1'b1;
      outSat_d   = satPeriod_q | stepSat;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_WIDTH'(1);
      satPeriod_q <= 1'b0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outSat_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      satPeriod_q <= satPeriod_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outSat_q    <= outSat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_sat   = outSat_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_piped_adder_accum.sv
// Testbench for piped_adder_accum. Two instances share all stimulus: the
// default configuration and a narrow one (ACC_WIDTH=9) that overflows easily.
// Honours ACCUM_SAT_EN the same way the design does.
module tb_piped_adder_accum;

  logic              clk = 1'b0;
  logic              reset_n;
  logic signed [7:0] inData;
  logic              inValid;
  logic [15:0]       dumpLen;
  logic              start;
  logic              stop;
  logic              outReady;

  logic signed [23:0] outData0;
  logic               outValid0, outSat0, overrun0, busy0;
  logic signed [8:0]  outData1;
  logic               outValid1, outSat1, overrun1, busy1;

  int numChecks = 0;
  int numPass   = 0;

  // Reference model state, one slot per instance.
  int     accW [2] = '{24, 9};
  bit     mRun [2];
  longint mAcc [2];
  longint mCnt [2];
  longint mLen [2];
  bit     mSatP [2];
  longint mOData [2];
  bit     mOValid [2];
  bit     mOSat [2];
  bit     mOv [2];

  piped_adder_accum #(.IN_WIDTH(8), .ACC_WIDTH(24), .LEN_WIDTH(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
    .dump_len(dumpLen), .start(start), .stop(stop), .out_data(outData0),
    .out_valid(outValid0), .out_ready(outReady), .out_sat(outSat0),
    .overrun(overrun0), .busy(busy0)
  );

  piped_adder_accum #(.IN_WIDTH(8), .ACC_WIDTH(9), .LEN_WIDTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
    .dump_len(dumpLen), .start(start), .stop(stop), .out_data(outData1),
    .out_valid(outValid1), .out_ready(outReady), .out_sat(outSat1),
    .overrun(overrun1), .busy(busy1)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    numChecks++;
    if (got == exp) numPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Bring an unbounded sum back into a w-bit signed accumulator.
  task automatic fitAcc(input longint x, input int w, output longint y, output bit clipped);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    y = x;
    clipped = 1'b0;
`ifdef ACCUM_SAT_EN
    if (x > hi) begin
      y = hi;
      clipped = 1'b1;
    end else if (x < lo) begin
      y = lo;
      clipped = 1'b1;
    end
`else
    begin
      longint m;
      m = longint'(1) <<< w;
      y = x % m;
      if (y < 0) y = y + m;
      if (y > hi) y = y - m;
      if (y < lo) y = y + m;
    end
`endif
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mRun[k] = 1'b0; mAcc[k] = 0; mCnt[k] = 0; mLen[k] = 1; mSatP[k] = 1'b0;
      mOData[k] = 0; mOValid[k] = 1'b0; mOSat[k] = 1'b0; mOv[k] = 1'b0;
    end
  endtask

  // One clock of behaviour from the current inputs.
  task automatic modelStep(input int k);
    longint s;
    bit     clip;
    bit     loaded;
    loaded = 1'b0;
    if (start) begin
      mRun[k] = 1'b1; mAcc[k] = 0; mCnt[k] = 0; mSatP[k] = 1'b0; mOv[k] = 1'b0;
      mLen[k] = (dumpLen == 16'd0) ? 1 : longint'(dumpLen);
    end else if (stop && mRun[k]) begin
      mRun[k] = 1'b0; mAcc[k] = 0; mCnt[k] = 0; mSatP[k] = 1'b0;
    end else if (mRun[k] && inValid) begin
      fitAcc(mAcc[k] + longint'(inData), accW[k], s, clip);
      if (mCnt[k] == mLen[k] - 1) begin
        if (!mOValid[k] || outReady) begin
          mOData[k] = s; mOValid[k] = 1'b1; mOSat[k] = mSatP[k] | clip; loaded = 1'b1;
        end else begin
          mOv[k] = 1'b1;
        end
        mAcc[k] = 0; mCnt[k] = 0; mSatP[k] = 1'b0;
      end else begin
        mAcc[k] = s; mCnt[k] = mCnt[k] + 1; mSatP[k] = mSatP[k] | clip;
      end
    end
    if (!loaded && mOValid[k] && outReady) mOValid[k] = 1'b0;
  endtask

  task automatic compareAll();
    checkOutput("d0.out_data",  longint'(outData0),  mOData[0]);
    checkOutput("d0.out_valid", longint'(outValid0), longint'(mOValid[0]));
    checkOutput("d0.out_sat",   longint'(outSat0),   longint'(mOSat[0]));
    checkOutput("d0.overrun",   longint'(overrun0),  longint'(mOv[0]));
    checkOutput("d0.busy",      longint'(busy0),     longint'(mRun[0]));
    checkOutput("d1.out_data",  longint'(outData1),  mOData[1]);
    checkOutput("d1.out_valid", longint'(outValid1), longint'(mOValid[1]));
    checkOutput("d1.out_sat",   longint'(outSat1),   longint'(mOSat[1]));
    checkOutput("d1.overrun",   longint'(overrun1),  longint'(mOv[1]));
    checkOutput("d1.busy",      longint'(busy1),     longint'(mRun[1]));
  endtask

  // Model follows the design each active edge; outputs compared 1 unit later.
  always @(posedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++) modelStep(k);
      #1;
      compareAll();
    end
  end

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input bit st, input bit sp, input bit v, input int d, input bit rdy);
    @(negedge clk);
    start = st; stop = sp; inValid = v; inData = 8'(d); outReady = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; inValid = 1'b0; inData = '0;
    dumpLen = '0; outReady = 1'b0;
    modelReset();
    #12;
    checkOutput("rst.out_valid", longint'(outValid0), 0);
    checkOutput("rst.out_data",  longint'(outData0), 0);
    checkOutput("rst.busy",      longint'(busy0), 0);
    checkOutput("rst.overrun",   longint'(overrun0), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Four samples summed and dumped one cycle later.
    dumpLen = 16'd4;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 2, 1);
    applyStimulus(0, 0, 1, 3, 1);
    checkOutput("len4.early_valid", longint'(outValid0), 0);
    applyStimulus(0, 0, 1, 4, 1);
    checkOutput("len4.sum", longint'(outData0), 10);
    checkOutput("len4.valid", longint'(outValid0), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("len4.drained", longint'(outValid0), 0);

    // Back-to-back periods of two.
    dumpLen = 16'd2;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, -3, 1);
    applyStimulus(0, 0, 1, -5, 1);
    checkOutput("len2.first", longint'(outData0), -8);
    applyStimulus(0, 0, 1, 7, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("len2.second", longint'(outData0), 8);
    applyStimulus(0, 0, 0, 0, 1);

    // Full output slot: second dump lost, overrun sticky until start.
    dumpLen = 16'd1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 5, 0);
    applyStimulus(0, 0, 1, 6, 0);
    checkOutput("ovr.kept", longint'(outData0), 5);
    checkOutput("ovr.flag", longint'(overrun0), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ovr.cleared", longint'(overrun0), 0);
    checkOutput("ovr.data_held", longint'(outData0), 5);
    checkOutput("ovr.valid_held", longint'(outValid0), 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Zero length behaves as one; stop discards a partial period.
    dumpLen = 16'd0;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 9, 1);
    checkOutput("len0.a", longint'(outData0), 9);
    applyStimulus(0, 0, 1, -2, 1);
    checkOutput("len0.b", longint'(outData0), -2);
    dumpLen = 16'd4;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 1, 1, 7, 1);
    checkOutput("stop.idle", longint'(busy0), 0);
    applyStimulus(1, 0, 1, 9, 1);
    applyStimulus(0, 0, 1, 2, 1);
    applyStimulus(0, 0, 1, 3, 1);
    applyStimulus(0, 0, 1, 4, 1);
    applyStimulus(0, 0, 1, 5, 1);
    checkOutput("restart.sum", longint'(outData0), 14);

    // Narrow accumulator overflow.
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 127, 1);
    checkOutput("ovf.wide", longint'(outData0), 508);
`ifdef ACCUM_SAT_EN
    checkOutput("ovf.narrow", longint'(outData1), 255);
    checkOutput("ovf.sat", longint'(outSat1), 1);
`else
    checkOutput("ovf.narrow", longint'(outData1), -4);
    checkOutput("ovf.sat", longint'(outSat1), 0);
`endif

    // Asynchronous reset mid-period with a pending dump.
    dumpLen = 16'd8;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 0);
    applyStimulus(0, 0, 1, 4, 0);
    checkOutput("arst.pre_valid", longint'(outValid0), 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst.out_data",  longint'(outData0), 0);
    checkOutput("arst.out_valid", longint'(outValid0), 0);
    checkOutput("arst.busy",      longint'(busy0), 0);
    checkOutput("arst.out_sat",   longint'(outSat1), 0);
    checkOutput("arst.narrow",    longint'(outValid1), 0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 0, 1, 5, 1);
    checkOutput("arst.idle_busy", longint'(busy0), 0);
    checkOutput("arst.idle_valid", longint'(outValid0), 0);

    // Randomized traffic against the model.
    dumpLen = 16'd3;
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) dumpLen = 16'($urandom_range(0, 5));
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
                    $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
